// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: two-flop synchronizer plus per-bit persistence filter and a change strobe.
// Define SWITCH_DEBOUNCE_EDGE_EN to add per-bit RisingEdges/FallingEdges pulses alongside Changed.

module switch_debouncer_lane #(
    parameter int   CYCLES  = 8,
    parameter int   CW      = 3,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic deb_o,
    output logic upd_o
);
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample that matches the current output clears the count, so only an
    // unbroken run of CYCLES differing samples moves the output.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        upd_o = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = sync2_q;
                upd_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            deb_q   <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module switch_debouncer #(
    parameter int                      NUM_SWITCHES    = 16,
    parameter int                      DEBOUNCE_CYCLES = 1000000,
    parameter logic [NUM_SWITCHES-1:0] RESET_VALUE     = '0
) (
    input  logic                    SYSCLK,
    input  logic                    RST,
    input  logic [NUM_SWITCHES-1:0] Switches,
    output logic [NUM_SWITCHES-1:0] DebouncedSwitches,
    output logic                    Changed
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic [NUM_SWITCHES-1:0] RisingEdges,
    output logic [NUM_SWITCHES-1:0] FallingEdges
`endif
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [NUM_SWITCHES-1:0] upd;
    logic                    changed_q;

    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_lane
        switch_debouncer_lane #(
            .CYCLES (DEBOUNCE_CYCLES),
            .CW     (CW),
            .RST_VAL(RESET_VALUE[i])
        ) u_lane (
            .clk  (SYSCLK),
            .rst_n(RST),
            .raw_i(Switches[i]),
            .deb_o(DebouncedSwitches[i]),
            .upd_o(upd[i])
        );
    end

    always_ff @(posedge SYSCLK or negedge RST) begin
        if (!RST) changed_q <= 1'b0;
        else      changed_q <= |upd;
    end

    assign Changed = changed_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [NUM_SWITCHES-1:0] rise_q, fall_q;

    // An update always flips the bit, so the old level gives the direction.
    always_ff @(posedge SYSCLK or negedge RST) begin
        if (!RST) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= upd & ~DebouncedSwitches;
            fall_q <= upd &  DebouncedSwitches;
        end
    end

    assign RisingEdges  = rise_q;
    assign FallingEdges = fall_q;
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (DEBOUNCE_CYCLES=8): expectations are queued per edge
// index from the latency rules when stimulus is applied, and checked on the falling edge.
module tb_switch_debouncer;
    localparam int DC = 8;

    logic        SYSCLK = 1'b0;
    logic        RST    = 1'b0;
    logic [15:0] Switches = 16'h0000;
    logic [15:0] DebouncedSwitches;
    logic        Changed;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [15:0] RisingEdges, FallingEdges;
`endif

    switch_debouncer #(
        .NUM_SWITCHES   (16),
        .DEBOUNCE_CYCLES(DC),
        .RESET_VALUE    (16'h0000)
    ) dut (
        .SYSCLK           (SYSCLK),
        .RST              (RST),
        .Switches         (Switches),
        .DebouncedSwitches(DebouncedSwitches),
        .Changed          (Changed)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        ,
        .RisingEdges      (RisingEdges),
        .FallingEdges     (FallingEdges)
`endif
    );

    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        int          at;
        int          sid;
        logic [15:0] deb;
        logic        chg;
        logic [15:0] rise;
        logic [15:0] fall;
    } exp_t;

    exp_t sb[$];
    int   ecnt   = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    always @(posedge SYSCLK) ecnt <= ecnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge%0d got=%h exp=%h", tag, ecnt, got, exp);
        end
    endtask

    // Pop every entry due at this edge index; an entry already overdue is a miss.
    always @(negedge SYSCLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == ecnt) begin
                chk($sformatf("s%0d_deb", sb[i].sid), {16'h0, DebouncedSwitches}, {16'h0, sb[i].deb});
                chk($sformatf("s%0d_chg", sb[i].sid), {31'h0, Changed}, {31'h0, sb[i].chg});
`ifdef SWITCH_DEBOUNCE_EDGE_EN
                chk($sformatf("s%0d_rise", sb[i].sid), {16'h0, RisingEdges}, {16'h0, sb[i].rise});
                chk($sformatf("s%0d_fall", sb[i].sid), {16'h0, FallingEdges}, {16'h0, sb[i].fall});
`endif
                sb.delete(i);
            end else if (sb[i].at < ecnt) begin
                chk($sformatf("s%0d_missed", sb[i].sid), sb[i].at, ecnt);
                sb.delete(i);
            end
        end
    end

    task automatic push(input int sid, input int at, input logic [15:0] deb, input logic chg,
                        input logic [15:0] rise = 16'h0, input logic [15:0] fall = 16'h0);
        exp_t e;
        e.at = at; e.sid = sid; e.deb = deb; e.chg = chg; e.rise = rise; e.fall = fall;
        sb.push_back(e);
    endtask

    task automatic win(input int sid, input int from, input int to, input logic [15:0] deb);
        for (int t = from; t <= to; t++) push(sid, t, deb, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        Switches = 16'h0000;
        idle(3);
        RST = 1'b1;
        idle(2);
    endtask

    int n, m;

    initial begin
        idle(1);

        // s0: reset holds outputs low despite all-ones pins, then quiet zeros
        n = ecnt;
        RST = 1'b0;
        Switches = 16'hFFFF;
        win(0, n + 1, n + 5, 16'h0000);
        idle(5);
        n = ecnt;
        RST = 1'b1;
        Switches = 16'h0000;
        win(0, n + 1, n + 50, 16'h0000);
        idle(50);

        // s1: clean toggle, output moves DC+2 edges after the pin changes
        do_reset();
        n = ecnt;
        Switches = 16'h0001;
        win(1, n + 1, n + DC + 1, 16'h0000);
        push(1, n + DC + 2, 16'h0001, 1'b1, 16'h0001, 16'h0000);
        win(1, n + DC + 3, n + DC + 12, 16'h0001);
        idle(DC + 12);

        // s2: one cycle short of the filter length is rejected
        do_reset();
        n = ecnt;
        Switches = 16'h0008;
        win(2, n + 1, n + 25, 16'h0000);
        idle(DC - 1);
        Switches = 16'h0000;
        idle(26 - DC);

        // s3: nibble bounces for 20 cycles then settles on A
        do_reset();
        n = ecnt;
        win(3, n + 1, n + 20 + DC + 1, 16'h0000);
        push(3, n + 20 + DC + 2, 16'hA000, 1'b1, 16'hA000, 16'h0000);
        win(3, n + 20 + DC + 3, n + 20 + DC + 12, 16'hA000);
        for (int i = 0; i < 20; i++) begin
            Switches = (i % 2 == 0) ? 16'hF000 : 16'h0000;
            idle(1);
        end
        Switches = 16'hA000;
        idle(DC + 12);

        // s4: reset mid-count discards progress; full latency restarts at release
        do_reset();
        n = ecnt;
        Switches = 16'h0020;
        win(4, n + 1, n + 7 + 1 + DC + 1, 16'h0000);
        push(4, n + 8 + DC + 2, 16'h0020, 1'b1, 16'h0020, 16'h0000);
        win(4, n + 8 + DC + 3, n + 8 + DC + 9, 16'h0020);
        idle(7);
        RST = 1'b0;
        idle(1);
        RST = 1'b1;
        idle(DC + 9);

        // s5: bits settling on consecutive edges give back-to-back pulses
        do_reset();
        n = ecnt;
        Switches = 16'h0001;
        win(5, n + 1, n + DC + 1, 16'h0000);
        push(5, n + DC + 2, 16'h0001, 1'b1, 16'h0001, 16'h0000);
        push(5, n + DC + 3, 16'h0003, 1'b1, 16'h0002, 16'h0000);
        win(5, n + DC + 4, n + DC + 8, 16'h0003);
        idle(1);
        Switches = 16'h0003;
        idle(DC + 8);

        // s6: rise on two bits, then fall on one
        do_reset();
        n = ecnt;
        Switches = 16'h0081;
        win(6, n + 1, n + DC + 1, 16'h0000);
        push(6, n + DC + 2, 16'h0081, 1'b1, 16'h0081, 16'h0000);
        win(6, n + DC + 3, n + DC + 4, 16'h0081);
        idle(DC + 4);
        m = ecnt;
        Switches = 16'h0001;
        win(6, m + 1, m + DC + 1, 16'h0081);
        push(6, m + DC + 2, 16'h0001, 1'b1, 16'h0000, 16'h0080);
        win(6, m + DC + 3, m + DC + 7, 16'h0001);
        idle(DC + 7);

        for (int k = 0; k < 100 && sb.size() != 0; k++) idle(1);
        chk("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
